// File: rtl/pet_need_engine.sv
// Tracks NUM_NEEDS decaying need levels, the shared health level, the face code and the test-mode tick speed-up.
// State settles one clk after its inputs; `changed` follows one clk later. Pulse inputs are always accepted (no backpressure).
module pet_need_engine #(
    parameter int NUM_NEEDS     = 5,
    parameter int LVL_W         = 4,
    parameter int LVL_MAX       = 9,
    parameter int CARE_STEP     = 2,
    parameter int TICK_DIV      = 50_000_000,
    parameter int TEST_SPEEDUP  = 60,
    parameter logic [NUM_NEEDS*16-1:0] DECAY_SEC = {16'd1800, 16'd600, 16'd1200, 16'd900, 16'd1500},
    parameter int HEAL_SEC      = 120,
    parameter int HEAL_MIN      = 5,
    parameter int SICK_TH       = 3,
    parameter int FACE_TICKS    = 1,
    parameter int TEST_HOLD_CYC = 250_000_000,
    localparam int SEL_W = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sel_next,
    input  logic                       care,
    input  logic [NUM_NEEDS-1:0]       auto_care,
    input  logic                       test_hold,
    output logic [SEL_W-1:0]           sel,
    output logic [NUM_NEEDS*LVL_W-1:0] levels,
    output logic [LVL_W-1:0]           health,
    output logic [2:0]                 face,
    output logic                       dead,
    output logic                       test_mode,
    output logic                       changed
);
    typedef enum logic [2:0] {
        F_NORMAL = 3'd0,
        F_HAPPY  = 3'd1,
        F_SAD    = 3'd2,
        F_SLEEPY = 3'd3,
        F_SICK   = 3'd4,
        F_DEAD   = 3'd5
    } face_t;

    localparam int REQ_W = $clog2(2*NUM_NEEDS + 1);
    localparam int HW    = ((LVL_W > REQ_W) ? LVL_W : REQ_W) + 1;
    localparam int OBS_W = SEL_W + NUM_NEEDS*LVL_W + LVL_W + 3;

    localparam logic [31:0]      TICK_LIM_N = 32'(TICK_DIV - 1);
    localparam logic [31:0]      TICK_LIM_T = 32'(TICK_DIV / TEST_SPEEDUP - 1);
    localparam logic [31:0]      HOLD_LIM   = 32'(TEST_HOLD_CYC - 1);
    localparam logic [15:0]      HEAL_LIM   = 16'(HEAL_SEC - 1);
    localparam logic [15:0]      FACE_LOAD  = 16'(FACE_TICKS);
    localparam logic [LVL_W-1:0] LMAX       = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] LMIN_HEAL  = LVL_W'(HEAL_MIN);
    localparam logic [LVL_W-1:0] LONE       = LVL_W'(1);
    localparam logic [LVL_W:0]   CSTEP      = (LVL_W+1)'(CARE_STEP);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_NEEDS - 1);

    logic [31:0]      tick_cnt;
    logic [31:0]      hold_cnt;
    logic             hold_done;
    logic             test_mode_q;
    logic [15:0]      dcnt [NUM_NEEDS];
    logic [LVL_W-1:0] lvl  [NUM_NEEDS];
    logic [LVL_W-1:0] health_q;
    logic             dead_q;
    logic [SEL_W-1:0] sel_q;
    face_t            face_q;
    logic [15:0]      react_tmr;
    logic             react_sad;
    logic [15:0]      heal_cnt;
    logic [OBS_W-1:0] prev_obs;
    logic             changed_q;

    logic             tick;
    logic             toggle;
    logic [NUM_NEEDS-1:0] care_ev;
    logic [NUM_NEEDS-1:0] decay_ev;
    logic [NUM_NEEDS-1:0] over_req;
    logic [NUM_NEEDS-1:0] zero_req;
    logic [LVL_W:0]   care_sum [NUM_NEEDS];
    logic [LVL_W-1:0] lvl_care [NUM_NEEDS];
    logic [LVL_W-1:0] lvl_nxt  [NUM_NEEDS];
    logic [15:0]      dcnt_nxt [NUM_NEEDS];
    logic [REQ_W-1:0] req_sum;
    logic [HW-1:0]    h_wide;
    logic             heal_ev;
    logic             all_ok;
    logic             any_zero;
    logic [LVL_W-1:0] health_nxt;
    logic             dead_nxt;
    logic [15:0]      tmr_nxt;
    logic             sad_nxt;
    face_t            face_nxt;
    logic [OBS_W-1:0] obs;

    always_comb begin
        tick   = (tick_cnt >= (test_mode_q ? TICK_LIM_T : TICK_LIM_N));
        toggle = test_hold && !hold_done && (hold_cnt == HOLD_LIM);

        // Care lands before decay so an overcared full need still decays this cycle.
        for (int i = 0; i < NUM_NEEDS; i++) begin
            care_ev[i]  = !dead_q && (auto_care[i] || (care && (sel_q == SEL_W'(i))));
            decay_ev[i] = tick && (dcnt[i] == (DECAY_SEC[i*16 +: 16] - 16'd1));
            dcnt_nxt[i] = !tick ? dcnt[i] : (decay_ev[i] ? 16'd0 : dcnt[i] + 16'd1);
            over_req[i] = care_ev[i] && (lvl[i] == LMAX);
            care_sum[i] = {1'b0, lvl[i]} + CSTEP;
            lvl_care[i] = lvl[i];
            if (care_ev[i] && !over_req[i])
                lvl_care[i] = (care_sum[i] > {1'b0, LMAX}) ? LMAX : care_sum[i][LVL_W-1:0];
            zero_req[i] = decay_ev[i] && (lvl_care[i] == '0);
            lvl_nxt[i]  = (decay_ev[i] && (lvl_care[i] != '0)) ? lvl_care[i] - LONE : lvl_care[i];
        end

        req_sum  = '0;
        all_ok   = 1'b1;
        any_zero = 1'b0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            req_sum = req_sum + REQ_W'(over_req[i]) + REQ_W'(zero_req[i]);
            if (lvl_nxt[i] < LMIN_HEAL)
                all_ok = 1'b0;
            if (lvl_nxt[i] == '0)
                any_zero = 1'b1;
        end

        h_wide = HW'(health_q);
        if (HW'(req_sum) >= h_wide)
            h_wide = '0;
        else
            h_wide = h_wide - HW'(req_sum);
        heal_ev = tick && (heal_cnt == HEAL_LIM);
        if (heal_ev && all_ok && (h_wide < HW'(LVL_MAX)))
            h_wide = h_wide + HW'(1);
        health_nxt = h_wide[LVL_W-1:0];
        dead_nxt   = dead_q || (health_nxt == '0);

        tmr_nxt = react_tmr;
        sad_nxt = react_sad;
        if (|care_ev) begin
            tmr_nxt = FACE_LOAD;
            sad_nxt = |over_req;
        end else if (tick && (react_tmr != '0)) begin
            tmr_nxt = react_tmr - 16'd1;
        end

        if (dead_nxt)
            face_nxt = F_DEAD;
        else if (health_nxt <= LVL_W'(SICK_TH))
            face_nxt = F_SICK;
        else if (tmr_nxt != '0)
            face_nxt = sad_nxt ? F_SAD : F_HAPPY;
        else if (any_zero)
            face_nxt = F_SLEEPY;
        else
            face_nxt = F_NORMAL;

        levels = '0;
        for (int i = 0; i < NUM_NEEDS; i++)
            levels[i*LVL_W +: LVL_W] = lvl[i];
    end

    assign sel       = sel_q;
    assign health    = health_q;
    assign face      = face_q;
    assign dead      = dead_q;
    assign test_mode = test_mode_q;
    assign changed   = changed_q;
    assign obs       = {sel_q, levels, health_q, face_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            hold_done   <= 1'b0;
            test_mode_q <= 1'b0;
            for (int i = 0; i < NUM_NEEDS; i++) begin
                dcnt[i] <= '0;
                lvl[i]  <= LMAX;
            end
            health_q  <= LMAX;
            dead_q    <= 1'b0;
            sel_q     <= '0;
            face_q    <= F_NORMAL;
            react_tmr <= '0;
            react_sad <= 1'b0;
            heal_cnt  <= '0;
            prev_obs  <= {{SEL_W{1'b0}}, {NUM_NEEDS{LMAX}}, LMAX, F_NORMAL};
            changed_q <= 1'b0;
        end else begin
            tick_cnt <= (toggle || tick) ? '0 : tick_cnt + 32'd1;

            // One toggle per press; the button must be released before it can fire again.
            if (!test_hold) begin
                hold_cnt  <= '0;
                hold_done <= 1'b0;
            end else if (!hold_done) begin
                if (toggle) begin
                    hold_done   <= 1'b1;
                    test_mode_q <= !test_mode_q;
                end else begin
                    hold_cnt <= hold_cnt + 32'd1;
                end
            end

            if (!dead_q) begin
                if (sel_next)
                    sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                for (int i = 0; i < NUM_NEEDS; i++) begin
                    dcnt[i] <= dcnt_nxt[i];
                    lvl[i]  <= lvl_nxt[i];
                end
                if (tick)
                    heal_cnt <= heal_ev ? 16'd0 : heal_cnt + 16'd1;
                health_q  <= health_nxt;
                dead_q    <= dead_nxt;
                face_q    <= face_nxt;
                react_tmr <= tmr_nxt;
                react_sad <= sad_nxt;
            end

            prev_obs  <= obs;
            changed_q <= (obs != prev_obs);
        end
    end
endmodule
